// File: rtl/dac_bus_controller.sv
// DAC bus slave: register file, sample FIFO and rate-divided playback engine
// behind a bus_enable/acknowledge handshake with a level interrupt.
module dac_bus_controller #(
  parameter int DAC_W       = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 1133
) (
  input  logic             clk_clk,
  input  logic             rst_reset_n,
  input  logic [2:0]       bus_address,
  input  logic             bus_bus_enable,
  input  logic             bus_rw,
  input  logic [3:0]       bus_byte_enable,
  input  logic [31:0]      bus_write_data,
  output logic [31:0]      bus_read_data,
  output logic             bus_acknowledge,
  output logic             bus_irq,
  output logic [DAC_W-1:0] dac_data,
  output logic             dac_strobe
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_DIV    = 3'd3;
  localparam logic [2:0] REG_THRESH = 3'd4;

  typedef enum logic [1:0] {IDLE, ACK, GAP} bus_state_t;

  bus_state_t        state, state_nxt;
  logic [31:0]       rd_q, rd_val;
  logic              enable, irq_en, underrun, overflow;
  logic [15:0]       divider, cnt;
  logic [8:0]        thresh;
  logic [DAC_W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic              unused_wdata;

  // Only the IDLE state samples a request; ACK and GAP make each transfer 3 cycles.
  wire access    = (state == IDLE) && bus_bus_enable;
  wire wr_en     = access && !bus_rw;
  wire push      = wr_en && (bus_address == REG_DATA) && (|bus_byte_enable);
  wire flush     = wr_en && (bus_address == REG_CTRL) && bus_byte_enable[0] && bus_write_data[2];
  wire clr_under = wr_en && (bus_address == REG_STATUS) && bus_byte_enable[1] && bus_write_data[11];
  wire clr_over  = wr_en && (bus_address == REG_STATUS) && bus_byte_enable[1] && bus_write_data[12];

  wire empty     = (level == '0);
  wire full      = (level == LW'(FIFO_DEPTH));
  wire tick      = enable && (cnt == 16'd0);
  wire pop       = tick && !empty && !flush;
  wire push_ok   = push && !full && !flush;

  assign unused_wdata    = ^bus_write_data;
  assign bus_acknowledge = (state == ACK);
  assign bus_read_data   = (state == ACK) ? rd_q : '0;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (bus_bus_enable) state_nxt = ACK;
      ACK:     state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (bus_address)
      REG_STATUS: begin
        rd_val[LW-1:0] = level;
        rd_val[9]      = empty;
        rd_val[10]     = full;
        rd_val[11]     = underrun;
        rd_val[12]     = overflow;
      end
      REG_CTRL:   rd_val[1:0]  = {irq_en, enable};
      REG_DIV:    rd_val[15:0] = divider;
      REG_THRESH: rd_val[8:0]  = thresh;
      default:    rd_val = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      state <= IDLE;
      rd_q  <= '0;
    end else begin
      state <= state_nxt;
      if (access) rd_q <= bus_rw ? rd_val : '0;
    end
  end

  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      divider  <= 16'(DEFAULT_DIV);
      thresh   <= 9'(FIFO_DEPTH / 2);
      underrun <= 1'b0;
      overflow <= 1'b0;
      bus_irq  <= 1'b0;
    end else begin
      if (wr_en && bus_address == REG_CTRL && bus_byte_enable[0])
        {irq_en, enable} <= bus_write_data[1:0];
      if (wr_en && bus_address == REG_DIV) begin
        if (bus_byte_enable[0]) divider[7:0]  <= bus_write_data[7:0];
        if (bus_byte_enable[1]) divider[15:8] <= bus_write_data[15:8];
      end
      if (wr_en && bus_address == REG_THRESH) begin
        if (bus_byte_enable[0]) thresh[7:0] <= bus_write_data[7:0];
        if (bus_byte_enable[1]) thresh[8]   <= bus_write_data[8];
      end
      // Sticky flags: a set in the same cycle as a clear wins.
      if (tick && empty)      underrun <= 1'b1;
      else if (clr_under)     underrun <= 1'b0;
      if (push && full)       overflow <= 1'b1;
      else if (clr_over)      overflow <= 1'b0;
      bus_irq <= irq_en && ((enable && (9'(level) <= thresh)) || underrun || overflow);
    end
  end

  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: the sample storage has no reset; the pointers and level define what is valid.
  always_ff @(posedge clk_clk) begin
    if (push_ok) mem[wr_ptr] <= bus_write_data[DAC_W-1:0];
  end

  // Disabled engine tracks DIVIDER continuously, so a new period applies at once.
  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      cnt        <= 16'(DEFAULT_DIV);
      dac_data   <= '0;
      dac_strobe <= 1'b0;
    end else begin
      if (!enable || cnt == 16'd0) cnt <= divider;
      else                         cnt <= cnt - 1'b1;
      dac_strobe <= pop;
      if (pop) dac_data <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_dac_bus_controller.sv
// Self-checking bench for dac_bus_controller: register vector table, playback
// scoreboard, and hand-written sequences for FIFO, irq, handshake and reset corners.
module tb_dac_bus_controller;
  logic        clk_clk = 1'b0;
  logic        rst_reset_n = 1'b0;
  logic [2:0]  bus_address = '0;
  logic        bus_bus_enable = 1'b0;
  logic        bus_rw = 1'b0;
  logic [3:0]  bus_byte_enable = '0;
  logic [31:0] bus_write_data = '0;
  logic [31:0] bus_read_data;
  logic        bus_acknowledge;
  logic        bus_irq;
  logic [15:0] dac_data;
  logic        dac_strobe;

  int n_pass = 0;
  int n_total = 0;
  logic [15:0] exp_q[$];
  logic [31:0] rd_dummy;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  dac_bus_controller #(.DAC_W(16), .FIFO_DEPTH(16), .DEFAULT_DIV(1133)) dut (
    .clk_clk         (clk_clk),
    .rst_reset_n     (rst_reset_n),
    .bus_address     (bus_address),
    .bus_bus_enable  (bus_bus_enable),
    .bus_rw          (bus_rw),
    .bus_byte_enable (bus_byte_enable),
    .bus_write_data  (bus_write_data),
    .bus_read_data   (bus_read_data),
    .bus_acknowledge (bus_acknowledge),
    .bus_irq         (bus_irq),
    .dac_data        (dac_data),
    .dac_strobe      (dac_strobe)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard side: each strobe must deliver the oldest sample the model holds.
  always @(negedge clk_clk) begin
    if (rst_reset_n && dac_strobe) begin
      if (exp_q.size() == 0) check("strobe_unexpected", {31'b0, dac_strobe}, 32'd0);
      else check("dac_data", {16'b0, dac_data}, {16'b0, exp_q.pop_front()});
    end
  end

  task automatic bus_xfer(input logic rw, input logic [2:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rd);
    int n;
    n = 0;
    @(negedge clk_clk);
    bus_bus_enable = 1'b1; bus_rw = rw; bus_address = addr;
    bus_byte_enable = be; bus_write_data = wd;
    do begin
      @(negedge clk_clk);
      n++;
    end while (!bus_acknowledge && n < 8);
    check("ack_latency", n, 1);
    rd = bus_read_data;
    bus_bus_enable = 1'b0; bus_rw = 1'b0; bus_byte_enable = '0; bus_write_data = '0;
    @(negedge clk_clk);
    check("ack_single", {31'b0, bus_acknowledge}, 32'd0);
    check("rdata_outside_ack", bus_read_data, 32'd0);
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] rd;
    bus_xfer(1'b0, addr, be, wd, rd);
  endtask

  task automatic bus_read(input logic [2:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] rd;
    bus_xfer(1'b1, addr, 4'h0, 32'h0, rd);
    check(name, rd, exp);
  endtask

  task automatic push_sample(input logic [15:0] v);
    bus_write(3'd0, 4'hF, {16'hDEAD, v});
    if (exp_q.size() < 16) exp_q.push_back(v);
  endtask

  task automatic do_reset();
    rst_reset_n = 1'b0;
    bus_bus_enable = 1'b0; bus_rw = 1'b0; bus_address = '0;
    bus_byte_enable = '0; bus_write_data = '0;
    repeat (3) @(negedge clk_clk);
    exp_q.delete();
    rst_reset_n = 1'b1;
    @(negedge clk_clk);
  endtask

  initial begin
    vecs.push_back('{1'b0, 3'd0, 4'h0, 32'h0,         32'h0});
    vecs.push_back('{1'b0, 3'd1, 4'h0, 32'h0,         32'h200});
    vecs.push_back('{1'b0, 3'd2, 4'h0, 32'h0,         32'h0});
    vecs.push_back('{1'b0, 3'd3, 4'h0, 32'h0,         32'd1133});
    vecs.push_back('{1'b0, 3'd4, 4'h0, 32'h0,         32'd8});
    vecs.push_back('{1'b0, 3'd5, 4'h0, 32'h0,         32'h0});
    vecs.push_back('{1'b0, 3'd6, 4'h0, 32'h0,         32'h0});
    vecs.push_back('{1'b0, 3'd7, 4'h0, 32'h0,         32'h0});
    vecs.push_back('{1'b1, 3'd3, 4'h3, 32'h0001_2345, 32'h2345});
    vecs.push_back('{1'b1, 3'd3, 4'h1, 32'hFFFF_FFAA, 32'h23AA});
    vecs.push_back('{1'b1, 3'd3, 4'h2, 32'h0000_5500, 32'h55AA});
    vecs.push_back('{1'b1, 3'd4, 4'h2, 32'hFFFF_FFFF, 32'h108});
    vecs.push_back('{1'b1, 3'd4, 4'h1, 32'h0000_0003, 32'h103});
    vecs.push_back('{1'b1, 3'd2, 4'h1, 32'h0000_0006, 32'h2});
    vecs.push_back('{1'b1, 3'd2, 4'h2, 32'h0000_0001, 32'h2});
    vecs.push_back('{1'b1, 3'd5, 4'hF, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b1, 3'd0, 4'h0, 32'h0000_1234, 32'h0});
    vecs.push_back('{1'b0, 3'd1, 4'h0, 32'h0,         32'h200});

    // Reset state and register access table.
    do_reset();
    check("rst_read_data", bus_read_data, 32'h0);
    check("rst_ack", {31'b0, bus_acknowledge}, 32'h0);
    check("rst_irq", {31'b0, bus_irq}, 32'h0);
    check("rst_dac_data", {16'b0, dac_data}, 32'h0);
    check("rst_strobe", {31'b0, dac_strobe}, 32'h0);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].be, vecs[i].wdata);
      bus_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_addr%0d", i, vecs[i].addr));
    end

    // Playback at DIVIDER = 3 then underrun with held output.
    do_reset();
    bus_write(3'd3, 4'h3, 32'd3);
    push_sample(16'h1111);
    push_sample(16'h2222);
    push_sample(16'h3333);
    bus_write(3'd2, 4'h1, 32'h1);
    begin
      int t[$];
      for (int c = 0; c < 20; c++) begin
        @(negedge clk_clk);
        if (dac_strobe) t.push_back(c);
      end
      check("play_strobe_count", t.size(), 3);
      if (t.size() == 3) begin
        check("play_period_1", t[1] - t[0], 4);
        check("play_period_2", t[2] - t[1], 4);
      end
    end
    check("play_dac_hold", {16'b0, dac_data}, 32'h3333);
    check("play_sb_drained", exp_q.size(), 0);
    bus_read(3'd1, 32'hA00, "play_status_underrun");

    // Overflow, lane-gated clear, flush.
    do_reset();
    for (int i = 0; i < 17; i++) push_sample(16'hA000 + 16'(i));
    bus_read(3'd1, 32'h1410, "ovf_status");
    bus_write(3'd1, 4'h1, 32'h1000);
    bus_read(3'd1, 32'h1410, "ovf_lane0_no_clear");
    bus_write(3'd1, 4'h2, 32'h1000);
    bus_read(3'd1, 32'h0410, "ovf_cleared");
    bus_write(3'd2, 4'h1, 32'h4);
    exp_q.delete();
    bus_read(3'd1, 32'h200, "ovf_flushed");

    // Low-watermark interrupt timing, then flush keeps irq asserted.
    do_reset();
    bus_write(3'd3, 4'h3, 32'd0);
    bus_write(3'd4, 4'h1, 32'd2);
    for (int i = 0; i < 4; i++) push_sample(16'hB000 + 16'(i));
    check("irq_idle_low", {31'b0, bus_irq}, 32'h0);
    begin
      int sc, sc_at;
      bit seen;
      sc = 0; sc_at = -1; seen = 1'b0;
      fork
        bus_write(3'd2, 4'h1, 32'h3);
        for (int i = 0; i < 10; i++) begin
          @(negedge clk_clk);
          if (dac_strobe) sc++;
          if (bus_irq && !seen) begin
            seen = 1'b1;
            sc_at = sc;
          end
        end
      join
      check("irq_rise_at_level2", sc_at, 3);
      check("irq_pop_count", sc, 4);
    end
    bus_write(3'd2, 4'h1, 32'h7);
    exp_q.delete();
    bus_read(3'd1, 32'hA00, "irq_status_flushed");
    check("irq_stays_high", {31'b0, bus_irq}, 32'h1);

    // Request held for 6 cycles: two acknowledges 3 cycles apart; upper lane ignored.
    do_reset();
    begin
      int ack_at[$];
      @(negedge clk_clk);
      bus_bus_enable = 1'b1; bus_rw = 1'b0; bus_address = 3'd4;
      bus_byte_enable = 4'h1; bus_write_data = 32'hFFFF_FFFF;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk_clk);
        if (bus_acknowledge) ack_at.push_back(c);
      end
      bus_bus_enable = 1'b0; bus_byte_enable = '0; bus_write_data = '0;
      check("held_ack_count", ack_at.size(), 2);
      if (ack_at.size() == 2) check("held_ack_spacing", ack_at[1] - ack_at[0], 3);
    end
    bus_read(3'd4, 32'h0FF, "held_thresh");

    // Reset asserted during ACK with 5 samples queued.
    do_reset();
    for (int i = 0; i < 5; i++) push_sample(16'hC000 + 16'(i));
    bus_read(3'd1, 32'h5, "rst_mid_level5");
    @(negedge clk_clk);
    bus_bus_enable = 1'b1; bus_rw = 1'b1; bus_address = 3'd1;
    @(posedge clk_clk);
    #1;
    check("rst_mid_ack_before", {31'b0, bus_acknowledge}, 32'h1);
    rst_reset_n = 1'b0;
    #1;
    check("rst_mid_ack_drop", {31'b0, bus_acknowledge}, 32'h0);
    check("rst_mid_rdata_drop", bus_read_data, 32'h0);
    bus_bus_enable = 1'b0; bus_rw = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk_clk);
    rst_reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_clk);
      check("rst_mid_no_ack", {31'b0, bus_acknowledge}, 32'h0);
    end
    bus_read(3'd1, 32'h200, "rst_mid_status");
    bus_read(3'd3, 32'd1133, "rst_mid_divider");
    bus_read(3'd4, 32'd8, "rst_mid_thresh");
    bus_read(3'd2, 32'h0, "rst_mid_ctrl");

    check("sb_final_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
